data_mem_responder: RTL

- Responder end of the CPU data-memory bus: accepts dispatch_read / dispatch_write with BYTE/WORD/DWORD width and returns load data.
- Sits between the cpu core and an on-chip byte-enabled BRAM that holds the data segment.
- Owns busy generation, lane steering, alignment checking and read-latency tracking, so the core only sees a busy/valid handshake.

---
 rtl/mem.sv | 52 +++++
 rtl/data_bram.sv | 33 +++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem.sv
// Shared data-memory bus types and lane helpers, used by the responder and by the core.
package mem;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        WORD  = 2'd1,
        DWORD = 2'd2
    } MemWidth;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } RespState;

    function automatic logic is_aligned(MemWidth width, logic [1:0] off);
        case (width)
            BYTE:    return 1'b1;
            WORD:    return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(MemWidth width, logic [1:0] off);
        case (width)
            BYTE:    return 4'b0001 << off;
            WORD:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Right-aligned store data copied onto every lane it could land on
    function automatic logic [31:0] lane_replicate(MemWidth width, logic [31:0] data);
        case (width)
            BYTE:    return {4{data[7:0]}};
            WORD:    return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(logic [31:0] word, MemWidth width, logic [1:0] off);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (width)
            BYTE:    return {24'h0, shifted[7:0]};
            WORD:    return {16'h0, shifted[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_bram.sv
// Single-port 32-bit BRAM with byte write enables and a LATENCY-deep registered read path.
module data_bram #(
    parameter int unsigned WORD_ADDR_WIDTH = 15,
    parameter int unsigned LATENCY         = 2,
    parameter string       INIT_FILE       = ""
) (
    input  logic                       clk,
    input  logic [3:0]                 we,
    input  logic [WORD_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata
);
    localparam int unsigned DEPTH = 1 << WORD_ADDR_WIDTH;

    logic [31:0] ram  [DEPTH];
    logic [31:0] pipe [LATENCY];

    // Read-first port: array read register followed by LATENCY-1 output stages
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                ram[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        pipe[0] <= ram[addr];
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign rdata = pipe[LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory bus: accepts loads/stores, steers byte lanes,
// flags misalignment and tracks BRAM read latency behind a busy/valid handshake.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter string       INIT_FILE    = ""
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [31:0]  addr,
    input  mem::MemWidth mem_width,
    input  logic         dispatch_read,
    input  logic         dispatch_write,
    input  logic [31:0]  write_data,
    output logic         busy,
    output logic [31:0]  read_data,
    output logic         read_valid,
    output logic         misaligned
);
    import mem::*;

    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W   = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

    RespState               state, next_state;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    MemWidth                width_q, width_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic                   busy_d, read_valid_d, misaligned_d;
    logic [31:0]            read_data_d;

    logic [3:0]             bram_we;
    logic [WORD_AW-1:0]     bram_addr;
    logic [31:0]            bram_rdata;

    // Upper address bits only alias the memory
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH];

    data_bram #(
        .WORD_ADDR_WIDTH (WORD_AW),
        .LATENCY         (BRAM_LATENCY),
        .INIT_FILE       (INIT_FILE)
    ) u_bram (
        .clk   (clk_in),
        .we    (bram_we),
        .addr  (bram_addr),
        .wdata (lane_replicate(width_q, wdata_q)),
        .rdata (bram_rdata)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            busy       <= 1'b0;
            read_valid <= 1'b0;
            read_data  <= '0;
            misaligned <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            width_q    <= BYTE;
            wdata_q    <= '0;
        end else begin
            state      <= next_state;
            busy       <= busy_d;
            read_valid <= read_valid_d;
            read_data  <= read_data_d;
            misaligned <= misaligned_d;
            cnt        <= cnt_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            wdata_q    <= wdata_d;
        end
    end

    // While idle the live address is presented so the read pipeline starts on the accept edge
    always_comb begin
        next_state   = state;
        busy_d       = 1'b0;
        read_valid_d = 1'b0;
        misaligned_d = 1'b0;
        read_data_d  = read_data;
        cnt_d        = cnt;
        addr_d       = addr_q;
        width_d      = width_q;
        wdata_d      = wdata_q;
        bram_we      = 4'b0000;
        bram_addr    = busy ? addr_q[ADDR_WIDTH-1:2] : addr[ADDR_WIDTH-1:2];

        case (state)
            IDLE, RESP: begin
                next_state = IDLE;
                if (dispatch_read || dispatch_write) begin
                    addr_d  = addr[ADDR_WIDTH-1:0];
                    width_d = mem_width;
                    wdata_d = write_data;
                    cnt_d   = CNT_W'(BRAM_LATENCY - 1);
                    if (!is_aligned(mem_width, addr[1:0])) begin
                        misaligned_d = 1'b1;
                        if (!dispatch_write) begin
                            read_valid_d = 1'b1;
                            read_data_d  = '0;
                        end
                    end else if (dispatch_write) begin
                        next_state = WRITE;
                        busy_d     = 1'b1;
                    end else begin
                        next_state = READ_WAIT;
                        busy_d     = 1'b1;
                    end
                end
            end
            WRITE: begin
                bram_we    = lane_enable(width_q, addr_q[1:0]);
                next_state = IDLE;
            end
            READ_WAIT: begin
                if (cnt == '0) begin
                    next_state   = RESP;
                    read_valid_d = 1'b1;
                    read_data_d  = lane_extract(bram_rdata, width_q, addr_q[1:0]);
                end else begin
                    cnt_d  = CNT_W'(cnt - 1'b1);
                    busy_d = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
